// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: SYNC prefix, bit stuffing, NRZI and EOP on a
// registered dp/dm pair, one bus bit per clock.
module usb_tx_line_encoder #(
   parameter int STUFF_LIMIT = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic pkt_start,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic pkt_last,
   output logic bit_ready,
   output logic dp,
   output logic dm,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int CW = $clog2(STUFF_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE, SYNC, DATA, STUFF, EOP1, EOP2, EOPJ
   } state_t;

   state_t          state;
   logic [2:0]      sync_cnt;
   logic [CW-1:0]   ones_cnt;
   logic [CW-1:0]   ones_inc;
   logic            last_pending;
   logic            aborted;

   assign ones_inc  = ones_cnt + CW'(1);
   assign bit_ready = (state == DATA);

   // NOTE: every register here uses non-blocking assignment, so all branches
   // see the pre-edge values of state, counters and pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dp           <= 1'b1;
         dm           <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         sync_cnt     <= '0;
         ones_cnt     <= '0;
         last_pending <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               dp <= 1'b1;
               dm <= 1'b0;
               if (pkt_start) begin
                  state        <= SYNC;
                  busy         <= 1'b1;
                  sync_cnt     <= '0;
                  ones_cnt     <= '0;
                  last_pending <= 1'b0;
                  aborted      <= 1'b0;
               end
            end
            SYNC: begin
               // Seven 0s (toggles) then a single 1 (hold) that seeds the ones run.
               if (sync_cnt == 3'd7) begin
                  ones_cnt <= CW'(1);
                  state    <= DATA;
               end else begin
                  dp       <= dm;
                  dm       <= dp;
                  sync_cnt <= sync_cnt + 3'd1;
               end
            end
            DATA: begin
               if (bit_valid) begin
                  if (bit_in) begin
                     ones_cnt <= ones_inc;
                     if (ones_inc == CW'(STUFF_LIMIT)) begin
                        state        <= STUFF;
                        last_pending <= pkt_last;
                     end else if (pkt_last) begin
                        state <= EOP1;
                     end
                  end else begin
                     dp       <= dm;
                     dm       <= dp;
                     ones_cnt <= '0;
                     if (pkt_last) state <= EOP1;
                  end
               end else begin
                  // Underrun: line holds this cycle, packet is closed with EOP.
                  err     <= 1'b1;
                  aborted <= 1'b1;
                  state   <= EOP1;
               end
            end
            STUFF: begin
               dp       <= dm;
               dm       <= dp;
               ones_cnt <= '0;
               state    <= last_pending ? EOP1 : DATA;
            end
            EOP1: begin
               dp    <= 1'b0;
               dm    <= 1'b0;
               state <= EOP2;
            end
            EOP2: begin
               dp    <= 1'b0;
               dm    <= 1'b0;
               state <= EOPJ;
            end
            EOPJ: begin
               dp       <= 1'b1;
               dm       <= 1'b0;
               done     <= ~aborted;
               busy     <= 1'b0;
               ones_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder: a bit-list reference model
// predicts every post-edge value of the pins and status outputs.
module tb_usb_tx_line_encoder;

   localparam logic [1:0] LJ   = 2'b10;
   localparam logic [1:0] LK   = 2'b01;
   localparam logic [1:0] LSE0 = 2'b00;

   logic clk = 1'b0;
   logic rst, pkt_start, bit_in, bit_valid, pkt_last;
   logic bit_ready, dp, dm, busy, done, err;

   usb_tx_line_encoder #(.STUFF_LIMIT(6)) dut (
      .clk(clk), .rst(rst), .pkt_start(pkt_start), .bit_in(bit_in),
      .bit_valid(bit_valid), .pkt_last(pkt_last), .bit_ready(bit_ready),
      .dp(dp), .dm(dm), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] line;
      logic       ready;
      logic       busy;
      logic       done;
      logic       err;
   } step_t;

   step_t      exp_q[$];
   logic [1:0] obs_q[$];
   logic       pay[64];
   int         n_vec  = 0;
   int         n_fail = 0;
   int         pkt_id = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] nrzi(input logic [1:0] l, input logic b);
      if (b) return l;
      return (l == LJ) ? LK : LJ;
   endfunction

   function automatic void push(input logic [1:0] l, input logic rd, input logic bz,
                                input logic dn, input logic er);
      exp_q.push_back({l, rd, bz, dn, er});
   endfunction

   // Predicts the outputs after each edge, from the pkt_start edge to the EOP J edge.
   function automatic void build_model(input int len, input int underrun_at);
      logic [1:0] l;
      int         ones;
      logic       ab;
      logic       last;
      exp_q.delete();
      l  = LJ;
      ab = 1'b0;
      push(l, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         l = nrzi(l, (i == 7));
         push(l, (i == 7), 1'b1, 1'b0, 1'b0);
      end
      ones = 1;
      for (int j = 0; j < len; j++) begin
         if (j == underrun_at) begin
            push(l, 1'b0, 1'b1, 1'b0, 1'b1);
            ab = 1'b1;
            break;
         end
         last = (j == len - 1);
         l    = nrzi(l, pay[j]);
         ones = pay[j] ? ones + 1 : 0;
         if (ones == 6) begin
            push(l, 1'b0, 1'b1, 1'b0, 1'b0);
            l    = nrzi(l, 1'b0);
            ones = 0;
         end
         push(l, !last, 1'b1, 1'b0, 1'b0);
      end
      push(LSE0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(LSE0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(LJ,   1'b0, 1'b0, !ab,  1'b0);
   endfunction

   task automatic run_packet(input int len, input int underrun_at, input int rst_at,
                             input bit poke_start);
      int    j = 0;
      step_t r;
      pkt_id++;
      build_model(len, underrun_at);
      obs_q.delete();
      pkt_start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < exp_q.size(); k++) begin
         r = exp_q[k];
         obs_q.push_back({dp, dm});
         check($sformatf("pkt%0d step%0d {dp,dm,ready,busy,done,err}", pkt_id, k),
               {dp, dm, bit_ready, busy, done, err}, r);
         pkt_start = 1'b0;
         if (r.ready && j == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            bit_valid = 1'b0;
            pkt_last  = 1'b0;
            check($sformatf("pkt%0d reset mid-DATA outputs", pkt_id),
                  {dp, dm, bit_ready, busy, done, err}, 6'b10_0000);
            return;
         end
         if (r.ready) begin
            if (j == underrun_at) begin
               bit_valid = 1'b0;
               pkt_last  = 1'b0;
            end else begin
               bit_valid = 1'b1;
               bit_in    = pay[j];
               pkt_last  = (j == len - 1);
               j++;
            end
         end else if (j < len && j != underrun_at) begin
            bit_valid = 1'b1;
            bit_in    = pay[j];
            pkt_last  = (j == len - 1);
         end else begin
            bit_valid = 1'b0;
            pkt_last  = 1'b0;
         end
         if (poke_start && r.ready && j == 2) pkt_start = 1'b1;
         if (k != exp_q.size() - 1) begin
            @(posedge clk); #1;
         end
      end
      bit_valid = 1'b0;
      pkt_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle outputs", {dp, dm, bit_ready, busy, done, err}, 6'b10_0000);
      end
   endtask

   task automatic check_line_str(input string tag, input string s);
      logic [1:0] e;
      check({tag, " length"}, obs_q.size(), s.len());
      for (int i = 0; i < s.len() && i < obs_q.size(); i++) begin
         e = (s[i] == "J") ? LJ : (s[i] == "K") ? LK : LSE0;
         check($sformatf("%s line[%0d]", tag, i), obs_q[i], e);
      end
   endtask

   task automatic set_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) pay[i] = v[i];
   endtask

   task automatic set_random(input int len);
      for (int i = 0; i < len; i++) pay[i] = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      int len, ur;
      rst = 1'b1; pkt_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; pkt_last = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset outputs", {dp, dm, bit_ready, busy, done, err}, 6'b10_0000);
      rst = 1'b0;
      idle(2);

      set_byte(8'hA5);
      run_packet(8, -1, -1, 1'b0);
      check_line_str("A5", "JKJKJKJKKKJJKJJKKSSJ");
      idle(2);

      set_byte(8'hFF);
      run_packet(8, -1, -1, 1'b0);
      check_line_str("FF", "JKJKJKJKKKKKKKJJJJSSJ");
      for (int i = 0; i < 5; i++) pay[i] = 1'b1;
      run_packet(5, -1, -1, 1'b0);
      check_line_str("five ones", "JKJKJKJKKKKKKKJSSJ");
      idle(2);

      set_random(8);
      run_packet(8, 3, -1, 1'b0);
      idle(2);

      set_random(10);
      run_packet(10, -1, -1, 1'b1);
      idle(1);

      set_random(10);
      run_packet(10, -1, 4, 1'b0);
      idle(3);
      set_byte(8'hA5);
      run_packet(8, -1, -1, 1'b0);
      check_line_str("A5 after reset", "JKJKJKJKKKJJKJJKKSSJ");
      idle(1);

      rst = 1'b1; pkt_start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; pkt_start = 1'b0;
      check("reset beats pkt_start", {dp, dm, bit_ready, busy, done, err}, 6'b10_0000);
      idle(3);

      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 24);
         set_random(len);
         ur = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
         run_packet(len, ur, -1, 1'b0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_tx_line_encoder.md
# usb_tx_line_encoder

Device-side transmit line encoder for the USB flash link. Consumes the serial payload bitstream produced by the packet serializer, one bit per clock, and drives the differential bus pins. Prepends SYNC, performs bit stuffing and NRZI encoding, and appends EOP. Its output is the wire that the host's read path samples.

## Interface
- STUFF_LIMIT, 6: number of consecutive 1s after which a stuffed 0 is inserted.
- clk  in  1  system clock; one bus bit per cycle.
- rst  in  1  synchronous, active-high reset.
- pkt_start  in  1  sampled in IDLE only; begins a packet.
- bit_in  in  1  next payload bit, already in wire order (LSB first).
- bit_valid  in  1  bit_in is valid.
- pkt_last  in  1  qualifies bit_in as the final payload bit.
- bit_ready  out  1  encoder accepts bit_in this cycle.
- dp, dm  out  1 each  registered bus pins: J = (1,0), K = (0,1), SE0 = (0,0).
- busy  out  1  high from the pkt_start edge until the EOP J cycle completes.
- done  out  1  one-cycle pulse on normal packet completion.
- err  out  1  one-cycle pulse on underrun abort.

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP1, EOP2, EOPJ.
- IDLE: the line holds J. `pkt_start` moves the FSM to SYNC and raises `busy`. Outside IDLE, `pkt_start` is ignored.
- SYNC: emits 8 bits, seven 0s then one 1, under NRZI. The line sequence from J is K J K J K J K K. The ones counter is 1 at exit.
- NRZI:
  - A 0 toggles the line between J and K.
  - A 1 holds the line.
  - A stuffed bit is a 0 and toggles.
- DATA:
  - `bit_ready` = 1 when state = DATA (combinational).
  - A transfer occurs when `bit_valid` and `bit_ready` are both high at a clock edge. The bit is emitted on that edge.
  - Ones counter: increments on 1, clears on 0.
  - When the counter reaches STUFF_LIMIT, the next state is STUFF.
- STUFF: `bit_ready` = 0. Emits a 0 (toggle) and clears the counter. Then returns to DATA, or goes to EOP1 if the bit that triggered the stuff was the last bit.
- Last bit: an accepted bit with `pkt_last` = 1 leads to EOP1, after an optional STUFF cycle. A stuff triggered by the final bit is always emitted before EOP.
- EOP: EOP1 and EOP2 drive SE0. EOPJ drives J and pulses `done`. The FSM then returns to IDLE and `busy` falls.
- Underrun: `bit_valid` = 0 while in DATA aborts the packet.
  - `err` pulses.
  - The FSM goes directly to EOP1 and nothing is emitted that cycle (the line holds).
  - The aborted packet still ends in SE0, SE0, J, but `done` is not pulsed.
- Reset:
  - `dp` = 1, `dm` = 0, `bit_ready` = 0, `busy` = 0, `done` = 0, `err` = 0, state = IDLE, counter = 0.
  - Reset mid-packet forces J on the next edge with no EOP and no `done` or `err`.

## Timing
- `pkt_start` sampled at edge N: SYNC bits appear on edges N+1 through N+8. `bit_ready` is high in the cycle after edge N+8. The first payload bit appears at edge N+9.
- Steady state is one payload bit per cycle. Each STUFF adds one cycle.
- Last bit emitted at edge M (no stuff): SE0 at M+1 and M+2, J at M+3. `done` is high during the cycle after M+3, and `busy` falls then.
- Line-to-bit latency is zero cycles after the accepting edge, because the pins are registered on that edge.
- `pkt_start` and `rst` on the same edge: reset wins.

## Test plan
- Byte 0xA5 (bits 1,0,1,0,0,1,0,1), `pkt_last` on bit 8 -> line J, then KJKJKJKK, then K J J K J J K K, then SE0 SE0 J. `done` pulses once and `err` stays 0.
- Byte 0xFF -> a stuffed 0 appears after the 5th data 1, because the counter starts at 1 from SYNC. The payload occupies 9 line cycles: KKKKK J JJJ, then EOP.
- Five 1s with `pkt_last` on the 5th -> the stuff bit is emitted after the 5th 1 and before SE0. `bit_ready` is 0 in the STUFF cycle.
- `bit_valid` dropped after 3 data bits -> `err` pulses, the line shows SE0 SE0 J, `done` stays 0, and `busy` falls after J.
- `pkt_start` pulsed during DATA -> no effect, and the packet completes normally. `rst` asserted mid-DATA -> J on the next edge, all outputs at reset values, and a new `pkt_start` then encodes correctly.
- Back-to-back packets: `pkt_start` asserted in the cycle after the `done` pulse -> the second SYNC begins one edge later with no extra idle cycles.
